// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped serial transmitter on the shared 8-bit CPU bus.
// CPU writes bytes into a TX FIFO (addr 0), polls status (addr 0 read) or the
// FIFO count (addr 1 read). A baud engine shifts each byte out on tx, LSB first.
// Optional build macro UART_TX_PARITY_EN: adds an even-parity bit (8E1 frames)
// and reports it through status bit4. Without it, frames are 8N1.
module uart_tx_port #(
   parameter int CLKS_PER_BIT    = 16,
   parameter int FIFO_DEPTH_LOG2 = 3
) (
   input  logic       clk,
   input  logic       reset,
   inout  wire  [7:0] data_bus,
   input  logic       address,
   input  logic       cs,
   input  logic       write,
   input  logic       read,
   output logic       tx,
   output logic       irq
);

   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int CW    = FIFO_DEPTH_LOG2 + 1;
   localparam int BW    = $clog2(CLKS_PER_BIT);

   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

`ifdef UART_TX_PARITY_EN
   localparam logic PARITY_FLAG = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_e;

   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction
`else
   localparam logic PARITY_FLAG = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd4
   } state_e;
`endif

   // FIFO state
   logic [7:0]                 fifo_mem_q [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]              count_q, count_d;
   logic                       ovf_q, ovf_d;

   // Bus edge detection
   logic wr_q;
   logic rd_stat_q;

   // Transmitter state
   state_e        state_q, state_d;
   logic [7:0]    shift_q, shift_d;
   logic [2:0]    idx_q, idx_d;
   logic [BW-1:0] baud_q, baud_d;
   logic          tx_q, tx_d;
   logic          irq_q, irq_d;
`ifdef UART_TX_PARITY_EN
   logic          par_q, par_d;
`endif

   // Combinational helpers
   logic       wr_strobe_s, push_s, push_ok_s, pop_s, ovf_set_s;
   logic       rd_stat_s, empty_s, full_s, busy_s, baud_tick_s;
   logic [7:0] status_s, rd_data_s;

   assign wr_strobe_s = cs & write & ~address;
   assign push_s      = wr_strobe_s & ~wr_q;          // one push per CPU write
   assign rd_stat_s   = cs & read & ~address;
   assign empty_s     = (count_q == CW'(0));
   assign full_s      = (count_q == DEPTH_C);
   assign busy_s      = (state_q != ST_IDLE);
   assign pop_s       = (state_q == ST_IDLE) & ~empty_s;
   // A pop in the same cycle frees a slot, so a push into a full FIFO survives.
   assign push_ok_s   = push_s & (~full_s | pop_s);
   assign ovf_set_s   = push_s & full_s & ~pop_s;
   assign baud_tick_s = (baud_q == BAUD_LAST);

   assign status_s = {3'b000, PARITY_FLAG, ovf_q, busy_s, full_s, empty_s};

   // Register read mux, straight from registers.
   always_comb begin
      rd_data_s = 8'h00;
      if (address == 1'b0) begin
         rd_data_s = status_s;
      end else begin
         rd_data_s = 8'(count_q);
      end
   end

   assign data_bus = (cs & read) ? rd_data_s : 8'bz;
   assign tx       = tx_q;
   assign irq      = irq_q;

   // FIFO pointer/count/overflow next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // Overflow is sticky; cleared when a status read ends.
      if (ovf_set_s) begin
         ovf_d = 1'b1;
      end else if (rd_stat_q & ~rd_stat_s) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Transmit FSM next-state, shifter, baud counter and registered outputs.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      baud_d  = baud_q;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         ST_IDLE: begin
            baud_d = BW'(0);
            if (pop_s) begin
               shift_d = fifo_mem_q[rd_ptr_q];
               idx_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
               par_d   = even_parity(fifo_mem_q[rd_ptr_q]);
`endif
               state_d = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (baud_tick_s) begin
               baud_d  = BW'(0);
               state_d = ST_DATA;
            end else begin
               baud_d  = baud_q + BW'(1);
            end
         end
         ST_DATA: begin
            if (baud_tick_s) begin
               baud_d  = BW'(0);
               shift_d = {1'b0, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (baud_tick_s) begin
               baud_d  = BW'(0);
               state_d = ST_STOP;
            end else begin
               baud_d  = baud_q + BW'(1);
            end
         end
`endif
         ST_STOP: begin
            if (baud_tick_s) begin
               baud_d  = BW'(0);
               state_d = ST_IDLE;
            end else begin
               baud_d  = baud_q + BW'(1);
            end
         end
         default: begin
            baud_d  = BW'(0);
            state_d = ST_IDLE;
         end
      endcase

      // Line level follows the state being entered, so tx is glitch-free.
      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: tx_d = par_d;
`endif
         default:   tx_d = 1'b1;
      endcase

      irq_d = (count_d == CW'(0)) & (state_d == ST_IDLE);
   end

   // FIFO storage; contents need no reset since pointers guard validity.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         fifo_mem_q[wr_ptr_q] <= data_bus;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         wr_q      <= 1'b0;
         rd_stat_q <= 1'b0;
         state_q   <= ST_IDLE;
         shift_q   <= 8'h00;
         idx_q     <= 3'd0;
         baud_q    <= '0;
         tx_q      <= 1'b1;
         irq_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         wr_q      <= wr_strobe_s;
         rd_stat_q <= rd_stat_s;
         state_q   <= state_d;
         shift_q   <= shift_d;
         idx_q     <= idx_d;
         baud_q    <= baud_d;
         tx_q      <= tx_d;
         irq_q     <= irq_d;
`ifdef UART_TX_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_port.sv
// Self-checking bench for uart_tx_port: scoreboard of written bytes checked
// against frames decoded from tx by a serial monitor.
module tb_uart_tx_port;

   localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
   localparam int         FB      = 11;
   localparam logic [7:0] PAR_BIT = 8'h10;
`else
   localparam int         FB      = 10;
   localparam logic [7:0] PAR_BIT = 8'h00;
`endif
   localparam int FRAME = FB * CPB;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       address = 1'b0;
   logic       cs = 1'b0;
   logic       write = 1'b0;
   logic       read = 1'b0;
   logic       tb_oe = 1'b0;
   logic [7:0] tb_dout = 8'h00;
   wire  [7:0] data_bus;
   wire        tx;
   wire        irq;

   assign data_bus = tb_oe ? tb_dout : 8'bz;

   uart_tx_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(3)) dut (
      .clk(clk), .reset(reset), .data_bus(data_bus), .address(address),
      .cs(cs), .write(write), .read(read), .tx(tx), .irq(irq)
   );

   int         n_tests = 0;
   int         n_fail = 0;
   int         cyc = 0;
   logic [7:0] exp_q[$];
   int         starts[$];
   int         mon_state = 0;
   int         mon_cnt = 0;
   int         mon_start = 0;
   logic       prev_tx = 1'b1;
   logic [10:0] rx_bits = 11'h000;

   initial forever #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic finish_frame();
      logic [7:0] got;
      logic [7:0] exp;
      got = rx_bits[8:1];
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL frame_unexpected: got data %h, expected no frame", got);
      end else begin
         exp = exp_q.pop_front();
         if (rx_bits[0] !== 1'b0 || got !== exp || rx_bits[FB-1] !== 1'b1) begin
            n_fail++;
            $display("FAIL frame: got data %h start %b stop %b, expected data %h start 0 stop 1",
                     got, rx_bits[0], rx_bits[FB-1], exp);
         end
`ifdef UART_TX_PARITY_EN
         n_tests++;
         if (rx_bits[9] !== ^exp) begin
            n_fail++;
            $display("FAIL frame_parity: got %b, expected %b for data %h", rx_bits[9], ^exp, exp);
         end
`endif
      end
      starts.push_back(mon_start);
      mon_state = 0;
   endtask

   // Serial monitor: detects start bit, samples mid-bit, checks frames.
   initial begin
      forever begin
         @(negedge clk);
         if (reset !== 1'b1) begin
            mon_state = 0;
         end else if (mon_state == 0) begin
            if (prev_tx === 1'b1 && tx === 1'b0) begin
               mon_state = 1;
               mon_cnt   = 0;
               mon_start = cyc;
            end
         end else begin
            mon_cnt++;
            if (mon_cnt % CPB == CPB / 2) begin
               rx_bits[mon_cnt / CPB] = tx;
               if (mon_cnt / CPB == FB - 1) finish_frame();
            end
         end
         prev_tx = tx;
      end
   end

   task automatic cpu_write(input logic a, input logic [7:0] d, input int hold,
                            input bit accept, output int pcyc);
      @(posedge clk); #1;
      address = a; cs = 1'b1; write = 1'b1; tb_oe = 1'b1; tb_dout = d;
      pcyc = cyc;
      if (accept) exp_q.push_back(d);
      repeat (hold) @(posedge clk);
      #1;
      cs = 1'b0; write = 1'b0; tb_oe = 1'b0;
   endtask

   task automatic cpu_read(input logic a, output logic [7:0] v);
      @(posedge clk); #1;
      address = a; cs = 1'b1; read = 1'b1;
      @(negedge clk);
      v = data_bus;
      @(posedge clk); #1;
      cs = 1'b0; read = 1'b0;
   endtask

   task automatic at_cycle(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic wait_start(output int s);
      for (int i = 0; i < 200; i++) begin
         if (mon_state != 0) break;
         @(negedge clk);
      end
      n_tests++;
      if (mon_state == 0) begin
         n_fail++;
         $display("FAIL start_timeout: got no start bit, expected one within 200 cycles");
      end
      s = mon_start;
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0 && mon_state == 0) break;
         @(negedge clk);
      end
      n_tests++;
      if (exp_q.size() != 0 || mon_state != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: got %0d bytes pending, expected 0", exp_q.size());
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [7:0] v;
      reset = 1'b0;
      repeat (5) @(negedge clk);
      n_tests++;
      if (tx !== 1'b1 || irq !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_outputs: got tx=%b irq=%b, expected tx=1 irq=1", tx, irq);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (50) @(negedge clk);
      n_tests++;
      if (tx !== 1'b1 || irq !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_outputs: got tx=%b irq=%b, expected tx=1 irq=1", tx, irq);
      end
      cpu_read(1'b0, v);
      n_tests++;
      if (v !== (8'h01 | PAR_BIT)) begin
         n_fail++;
         $display("FAIL reset_status: got %h, expected %h", v, 8'h01 | PAR_BIT);
      end
      cpu_read(1'b1, v);
      n_tests++;
      if (v !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_count: got %h, expected 00", v);
      end
      // Bus must be released when not selected or not reading.
      @(posedge clk); #1;
      cs = 1'b0; read = 1'b1; tb_oe = 1'b1; tb_dout = 8'h5A;
      @(negedge clk);
      n_tests++;
      if (data_bus !== 8'h5A) begin
         n_fail++;
         $display("FAIL bus_release_unselected: got %h, expected 5a", data_bus);
      end
      @(posedge clk); #1;
      cs = 1'b1; read = 1'b0; tb_dout = 8'hC3;
      @(negedge clk);
      n_tests++;
      if (data_bus !== 8'hC3) begin
         n_fail++;
         $display("FAIL bus_release_noread: got %h, expected c3", data_bus);
      end
      @(posedge clk); #1;
      cs = 1'b0; read = 1'b0; tb_oe = 1'b0;
   endtask

   task automatic test_single_frame();
      logic [7:0] v;
      int p, s;
      cpu_write(1'b0, 8'hA5, 3, 1'b1, p);
      cpu_read(1'b1, v);
      n_tests++;
      if (v !== 8'h00) begin
         n_fail++;
         $display("FAIL single_push_count: got %h, expected 00", v);
      end
      cpu_read(1'b0, v);
      n_tests++;
      if (v !== (8'h05 | PAR_BIT)) begin
         n_fail++;
         $display("FAIL single_busy_status: got %h, expected %h", v, 8'h05 | PAR_BIT);
      end
      wait_start(s);
      n_tests++;
      if (s - p !== 2) begin
         n_fail++;
         $display("FAIL start_latency: got %0d cycles, expected 2", s - p);
      end
      at_cycle(s + FRAME - 1);
      n_tests++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_in_frame: got %b, expected 0", irq);
      end
      at_cycle(s + FRAME);
      n_tests++;
      if (irq !== 1'b1) begin
         n_fail++;
         $display("FAIL irq_after_frame: got %b, expected 1", irq);
      end
      wait_drain(400);
   endtask

   task automatic test_back_to_back();
      logic [7:0] v;
      int p, base;
      base = starts.size();
      for (int i = 0; i < 9; i++) begin
         cpu_write(1'b0, 8'(i), 1, 1'b1, p);
         repeat (2) @(posedge clk);
      end
      cpu_read(1'b0, v);
      n_tests++;
      if (v !== (8'h06 | PAR_BIT)) begin
         n_fail++;
         $display("FAIL b2b_status_full: got %h, expected %h", v, 8'h06 | PAR_BIT);
      end
      cpu_read(1'b1, v);
      n_tests++;
      if (v !== 8'h08) begin
         n_fail++;
         $display("FAIL b2b_count: got %h, expected 08", v);
      end
      wait_drain(9 * (FRAME + 1) + 400);
      n_tests++;
      if (starts.size() !== base + 9) begin
         n_fail++;
         $display("FAIL b2b_frames: got %0d frames, expected 9", starts.size() - base);
      end else begin
         for (int i = 1; i < 9; i++) begin
            n_tests++;
            if (starts[base + i] - starts[base + i - 1] !== FRAME + 1) begin
               n_fail++;
               $display("FAIL b2b_period: got %0d cycles, expected %0d",
                        starts[base + i] - starts[base + i - 1], FRAME + 1);
            end
         end
      end
   endtask

   task automatic test_overflow();
      logic [7:0] v;
      int p;
      cpu_write(1'b0, 8'h11, 1, 1'b1, p);
      repeat (4) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         cpu_write(1'b0, 8'h20 + 8'(i), 1, 1'b1, p);
         repeat (2) @(posedge clk);
      end
      cpu_write(1'b0, 8'hFF, 1, 1'b0, p);
      repeat (2) @(posedge clk);
      cpu_read(1'b0, v);
      n_tests++;
      if (v !== (8'h0E | PAR_BIT)) begin
         n_fail++;
         $display("FAIL ovf_status: got %h, expected %h", v, 8'h0E | PAR_BIT);
      end
      cpu_read(1'b0, v);
      n_tests++;
      if (v !== (8'h06 | PAR_BIT)) begin
         n_fail++;
         $display("FAIL ovf_cleared: got %h, expected %h", v, 8'h06 | PAR_BIT);
      end
      wait_drain(9 * (FRAME + 1) + 400);
      cpu_read(1'b1, v);
      n_tests++;
      if (v !== 8'h00) begin
         n_fail++;
         $display("FAIL ovf_drained_count: got %h, expected 00", v);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] v;
      int p, s, base;
      cpu_write(1'b0, 8'h3C, 1, 1'b1, p);
      for (int i = 0; i < 4; i++) cpu_write(1'b0, 8'h41 + 8'(i), 1, 1'b1, p);
      wait_start(s);
      base = starts.size();
      at_cycle(s + CPB + CPB / 2);
      #1;
      n_tests++;
      if (tx !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_frame_tx: got %b, expected 0 (bit0 of 3c)", tx);
      end
      reset = 1'b0;
      #1;
      n_tests++;
      if (tx !== 1'b1) begin
         n_fail++;
         $display("FAIL async_reset_tx: got %b, expected 1", tx);
      end
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      cpu_read(1'b1, v);
      n_tests++;
      if (v !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_flush_count: got %h, expected 00", v);
      end
      repeat (3 * FRAME) @(negedge clk);
      n_tests++;
      if (starts.size() !== base || mon_state != 0 || irq !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_no_frames: got %0d new frames irq=%b, expected 0 irq=1",
                  starts.size() - base, irq);
      end
   endtask

   task automatic test_parity();
      logic [7:0] v;
      int p, s;
      cpu_write(1'b0, 8'h07, 1, 1'b1, p);
      wait_start(s);
      at_cycle(s + FRAME - 1);
      n_tests++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL parity_frame_len_early: got irq %b, expected 0", irq);
      end
      at_cycle(s + FRAME);
      n_tests++;
      if (irq !== 1'b1) begin
         n_fail++;
         $display("FAIL parity_frame_len: got irq %b, expected 1 at %0d cycles", irq, FRAME);
      end
      wait_drain(400);
      cpu_read(1'b0, v);
      n_tests++;
      if ((v & 8'h10) !== PAR_BIT) begin
         n_fail++;
         $display("FAIL parity_status_bit4: got %h, expected %h", v & 8'h10, PAR_BIT);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_overflow();
      test_reset_mid_frame();
      test_parity();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: got %0d pending, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
